display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
// Frame scheduler for display_decoder: time-shares one decoder between NUM_CH display channels
// (register values of the machine). Each frame it snapshots all channels, walks each enabled one,
// pulses the decoder's next_led once per segment bit, and shifts each returned led_data bit into
// an external 74HC595-style chain (sr_clk/sr_data), then latches the chain (sr_latch).
// PARAMETERS
// NUM_CH          4     number of display channels (1..8)
// DIV             4     system clocks per sr_clk half-period (>=1)
// BITS_PER_DIGIT  8     segment bits shifted per digit
// TIMEOUT         255   max cycles dec_busy may stay high before frame abort
// PORTS
// clk              in   1           system clock
// rst              in   1           synchronous, active-high reset
// start            in   1           frame request pulse; ignored while busy
// ch_data          in   NUM_CH*16   channel i value at [16i+15:16i]
// ch_digits        in   NUM_CH*2    channel i digit count at [2i+1:2i]; 0 = channel skipped
// busy             out  1           frame in progress
// frame_done       out  1           1-cycle pulse: frame shifted and latched
// err              out  1           1-cycle pulse: decoder timeout, frame aborted
// dec_data         out  16          to decoder data (snapshot of current channel)
// dec_digit_count  out  2           to decoder digit_count
// dec_next         out  1           to decoder next_led, 1-cycle pulse per bit
// dec_led_data     in   1           from decoder led_data
// dec_busy         in   1           from decoder busy
// sr_clk           out  1           shift clock, data sampled by chain on rising edge
// sr_data          out  1           serial segment bit
// sr_latch         out  1           storage-register latch, high for DIV cycles
// BEHAVIOUR
// - Reset: every output 0, FSM IDLE, counters 0; reset mid-frame aborts with no latch/done/err pulse.
// - start sampled high in IDLE: ch_data/ch_digits snapshotted; busy=1 from the next cycle; later
//   input changes do not affect the running frame. start while busy: ignored, not queued.
// - Channel order NUM_CH-1 down to 0; bits per channel = digits*BITS_PER_DIGIT (max 24, 5-bit count).
// - FSM states and transitions:
//   IDLE  -> LOAD on start.
//   LOAD  (1 cycle): drive dec_data/dec_digit_count for channel;
//         digits==0 -> next channel or LATCH if last; else -> REQ.
//   REQ   (1 cycle): dec_next=1 -> WAIT.
//   WAIT  (>=1 cycle): first cycle after REQ never samples; then when dec_busy==0 register
//         dec_led_data into sr_data -> SHLO. Timeout counter runs from REQ; reaching TIMEOUT with
//         dec_busy still 1 -> err pulse, IDLE (no latch).
//   SHLO  DIV cycles, sr_clk=0.
//   SHHI  DIV cycles, sr_clk=1; then: bits remain -> REQ; channel done -> LOAD next channel;
//         last channel done -> LATCH.
//   LATCH DIV cycles sr_latch=1, sr_clk=0 -> DONE.
//   DONE  (1 cycle): frame_done=1, busy=0 -> IDLE.
// - sr_data stable across the full SHLO+SHHI window; dec_data/dec_digit_count held per channel.
// - Frame length (dec_busy low immediately) from start edge:
//   1 + NUM_CH + nbits*(2+2*DIV) + DIV + 1 cycles.
// - All channels digits==0: no dec_next, no sr_clk edges; LATCH and frame_done still occur.
// - err and frame_done never both pulse in one frame.
// TESTING
// 1. NUM_CH=4, DIV=4, digits={0,2,0,0} (ch1=25), decoder model busy=0 -> 16 dec_next pulses,
//    16 sr_clk rising edges, 1 latch, frame_done at cycle 1+4+160+4+1=170 after start.
// 2. digits={3,0,0,1}, ch3=678, ch0=5 -> 32 bits; ch3's 24 bits shifted before ch0's 8,
//    bit stream equals model's led_data sequence per channel.
// 3. Decoder model holds dec_busy=1 for 3 cycles per bit -> each bit takes 3 extra cycles,
//    sr_data equals value at busy fall; no extra dec_next pulses.
// 4. dec_busy stuck 1 on bit 5, TIMEOUT=255 -> err pulse once, busy=0, no sr_latch, frame_done=0.
// 5. start again mid-frame and ch_data changed mid-frame -> single frame, shifted bits match
//    start-time snapshot.
// 6. rst asserted during SHHI of bit 10 -> next cycle all outputs 0, IDLE; new start runs full frame.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Purpose: frame scheduler time-sharing one display_decoder across NUM_CH channels into a 74HC595 chain.
// Latency: 1 + NUM_CH + nbits*(2+2*DIV) + DIV + 1 cycles per frame (decoder answering immediately).
// Backpressure: start ignored while busy (not queued); dec_busy stalls each bit, aborting after TIMEOUT cycles.
module display_scan_ctrl #(
   parameter int NUM_CH         = 4,
   parameter int DIV            = 4,
   parameter int BITS_PER_DIGIT = 8,
   parameter int TIMEOUT        = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_CH*16-1:0]   ch_data,
   input  logic [NUM_CH*2-1:0]    ch_digits,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   err,
   output logic [15:0]            dec_data,
   output logic [1:0]             dec_digit_count,
   output logic                   dec_next,
   input  logic                   dec_led_data,
   input  logic                   dec_busy,
   output logic                   sr_clk,
   output logic                   sr_data,
   output logic                   sr_latch
);

   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = 5;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_REQ   = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_SHLO  = 3'd4;
   localparam logic [2:0] S_SHHI  = 3'd5;
   localparam logic [2:0] S_LATCH = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   logic [2:0]    state;
   logic [CW-1:0] ch_idx;
   logic [BW-1:0] bit_cnt;   // bits still to shift for the current channel, including the one in flight
   logic [DW-1:0] div_cnt;
   logic [TW-1:0] tcnt;
   logic [15:0]   snap_data [NUM_CH];
   logic [1:0]    snap_dig  [NUM_CH];
   logic [15:0]   cur_data;
   logic [1:0]    cur_dig;
   logic          div_last;

   assign cur_data = snap_data[ch_idx];
   assign cur_dig  = snap_dig[ch_idx];
   assign div_last = (div_cnt == DW'(DIV - 1));

   // Output decode from state; decoder inputs only carry channel data while a frame runs
   always_comb begin
      busy            = (state != S_IDLE) && (state != S_DONE);
      frame_done      = (state == S_DONE);
      dec_next        = (state == S_REQ);
      sr_clk          = (state == S_SHHI);
      sr_latch        = (state == S_LATCH);
      dec_data        = busy ? cur_data : 16'd0;
      dec_digit_count = busy ? cur_dig  : 2'd0;
   end

   // Frame FSM: snapshot, walk channels high to low, one decoder request per shifted bit
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         ch_idx  <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         tcnt    <= '0;
         sr_data <= 1'b0;
         err     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            snap_data[i] <= '0;
            snap_dig[i]  <= '0;
         end
      end else begin
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     snap_data[i] <= ch_data[16*i +: 16];
                     snap_dig[i]  <= ch_digits[2*i +: 2];
                  end
                  ch_idx <= CW'(NUM_CH - 1);
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (cur_dig == 2'd0) begin
                  // empty channel: skip without touching the decoder
                  if (ch_idx == '0) begin
                     div_cnt <= '0;
                     state   <= S_LATCH;
                  end else begin
                     ch_idx <= ch_idx - CW'(1);
                  end
               end else begin
                  bit_cnt <= BW'(BITS_PER_DIGIT) * BW'(cur_dig);
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               // the request cycle itself counts toward the timeout
               tcnt  <= TW'(1);
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (!dec_busy) begin
                  sr_data <= dec_led_data;
                  div_cnt <= '0;
                  state   <= S_SHLO;
               end else if (tcnt == TW'(TIMEOUT)) begin
                  err   <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_SHLO: begin
               if (div_last) begin
                  div_cnt <= '0;
                  state   <= S_SHHI;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            S_SHHI: begin
               if (div_last) begin
                  div_cnt <= '0;
                  if (bit_cnt != BW'(1)) begin
                     bit_cnt <= bit_cnt - BW'(1);
                     state   <= S_REQ;
                  end else if (ch_idx == '0) begin
                     state <= S_LATCH;
                  end else begin
                     ch_idx <= ch_idx - CW'(1);
                     state  <= S_LOAD;
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            S_LATCH: begin
               if (div_last) begin
                  div_cnt <= '0;
                  state   <= S_DONE;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: decoder behavioural model, expected-bit scoreboard, frame-level checks.
// Shifted bits are compared on every sr_clk rise against a queue filled when each frame is requested.
// Directed frames cover skipping, multi-channel order, decoder stalls, timeout, restarts and reset.
module tb_display_scan_ctrl;

   localparam int NUM_CH = 4;
   localparam int DIV    = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [NUM_CH*16-1:0] ch_data = '0;
   logic [NUM_CH*2-1:0]  ch_digits = '0;
   logic                 busy, frame_done, err;
   logic [15:0]          dec_data;
   logic [1:0]           dec_digit_count;
   logic                 dec_next;
   logic                 dec_led_data = 1'b0;
   logic                 dec_busy = 1'b0;
   logic                 sr_clk, sr_data, sr_latch;

   display_scan_ctrl #(.NUM_CH(NUM_CH), .DIV(DIV), .BITS_PER_DIGIT(8), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .start(start), .ch_data(ch_data), .ch_digits(ch_digits),
      .busy(busy), .frame_done(frame_done), .err(err),
      .dec_data(dec_data), .dec_digit_count(dec_digit_count), .dec_next(dec_next),
      .dec_led_data(dec_led_data), .dec_busy(dec_busy),
      .sr_clk(sr_clk), .sr_data(sr_data), .sr_latch(sr_latch)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Decoder led_data for bit k of a channel value: any fixed, data-dependent pattern will do
   function automatic logic mbit(input logic [15:0] d, input int k);
      return d[k % 16] ^ ((k / 16) % 2 == 1);
   endfunction

   // ---------------- decoder model ----------------
   int   busy_len  = 0;
   int   stuck_bit = -1;
   int   m_cnt = 0, m_idx = 0, gbit = 0;
   logic m_pend = 1'b0;
   logic m_v;

   always @(negedge clk) begin
      if (!busy) begin
         dec_busy = 1'b0;
         m_cnt = 0; m_idx = 0; gbit = 0;
      end else if (dec_next) begin
         m_v = mbit(dec_data, m_idx);
         if (gbit == stuck_bit) begin
            dec_busy = 1'b1; m_cnt = 1000000;
         end else if (busy_len == 0) begin
            dec_busy = 1'b0; dec_led_data = m_v;
         end else begin
            dec_busy = 1'b1; m_cnt = busy_len; dec_led_data = ~m_v; m_pend = m_v;
         end
         m_idx = (m_idx + 1 == int'(dec_digit_count) * 8) ? 0 : m_idx + 1;
         gbit++;
      end else if (dec_busy) begin
         if (m_cnt == 0) begin
            dec_busy = 1'b0; dec_led_data = m_pend;
         end else begin
            m_cnt--;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic exp_q[$];
   int   cyc = 0;
   int   rises, nexts, dones, errs, latch_cyc, latch_clk_bad, done_cyc;
   logic prev_clk = 1'b0;
   logic held = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst) begin
         if (sr_clk && !prev_clk) begin
            rises++;
            if (exp_q.size() == 0) check("bit_unexpected", 1, 0);
            else check("bit", sr_data, exp_q.pop_front());
            held = sr_data;
         end
         if (!sr_clk && prev_clk) check("bit_hold", sr_data, held);
         if (dec_next) nexts++;
         if (frame_done) begin dones++; done_cyc = cyc; end
         if (err) errs++;
         if (sr_latch) begin
            latch_cyc++;
            if (sr_clk) latch_clk_bad++;
         end
      end
      prev_clk = sr_clk;
   end

   // ---------------- stimulus ----------------
   task automatic run_frame(input string name, input logic [63:0] d, input logic [7:0] dg,
                            input int blen, input int sbit, input int rbit, input bit disturb,
                            input int exp_bits, input int exp_lat);
      int start_cyc, waited;
      busy_len = blen; stuck_bit = sbit;
      rises = 0; nexts = 0; dones = 0; errs = 0; latch_cyc = 0; latch_clk_bad = 0; done_cyc = 0;
      exp_q.delete();
      for (int c = NUM_CH - 1; c >= 0; c--)
         for (int k = 0; k < int'(dg[2*c +: 2]) * 8; k++)
            exp_q.push_back(mbit(d[16*c +: 16], k));
      @(negedge clk);
      start = 1'b1; ch_data = d; ch_digits = dg; start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      check({name, "_busy"}, busy, 1);
      if (disturb) begin
         repeat (40) @(negedge clk);
         start = 1'b1; ch_data = ~d; ch_digits = ~dg;
         @(negedge clk);
         start = 1'b0;
      end
      if (rbit >= 0) begin
         waited = 0;
         while (!(rises == rbit + 1 && sr_clk) && waited < 5000) begin
            @(negedge clk); waited++;
         end
         check({name, "_reach_bit"}, rises, rbit + 1);
         rst = 1'b1;
         @(negedge clk);
         check({name, "_rst_outputs"},
               {busy, frame_done, err, dec_data, dec_digit_count, dec_next, sr_clk, sr_data, sr_latch}, 0);
         @(negedge clk);
         rst = 1'b0;
         repeat (20) @(negedge clk);
         check({name, "_rst_no_done"}, dones + errs + latch_cyc, 0);
         exp_q.delete();
         return;
      end
      waited = 0;
      while (dones == 0 && errs == 0 && waited < 20000) begin
         @(negedge clk); waited++;
      end
      check({name, "_finished"}, (dones + errs > 0), 1);
      repeat (30) @(negedge clk);
      check({name, "_idle_after"}, busy, 0);
      if (sbit >= 0) begin
         check({name, "_err_pulses"}, errs, 1);
         check({name, "_done_pulses"}, dones, 0);
         check({name, "_latch_cycles"}, latch_cyc, 0);
         check({name, "_rises"}, rises, sbit);
         check({name, "_next_pulses"}, nexts, sbit + 1);
         exp_q.delete();
      end else begin
         check({name, "_done_pulses"}, dones, 1);
         check({name, "_err_pulses"}, errs, 0);
         check({name, "_next_pulses"}, nexts, exp_bits);
         check({name, "_rises"}, rises, exp_bits);
         check({name, "_latch_cycles"}, latch_cyc, DIV);
         check({name, "_latch_clk_low"}, latch_clk_bad, 0);
         // start edge counts as cycle 1, the frame_done cycle as the last
         check({name, "_latency"}, done_cyc - start_cyc + 1, exp_lat);
         check({name, "_bits_left"}, exp_q.size(), 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, required < 1ms", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {busy, frame_done, err, dec_data, dec_digit_count, dec_next, sr_clk, sr_data, sr_latch}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // ch1 = 25, 2 digits: 16 bits, 1+4+160+4+1 = 170
      run_frame("one_ch",   64'h0000_0000_0019_0000, 8'h08, 0, -1, -1, 1'b0, 16, 170);
      // ch3 = 678 (3 digits), ch0 = 5 (1 digit), ch2/ch1 skipped: 32 bits, 1+4+320+4+1 = 330
      run_frame("two_ch",   64'h02A6_1234_5678_0005, 8'hC1, 0, -1, -1, 1'b0, 32, 330);
      // decoder busy 3 cycles per bit: 170 + 16*3 = 218
      run_frame("stall3",   64'h0000_0000_0019_0000, 8'h08, 3, -1, -1, 1'b0, 16, 218);
      // decoder never releases on bit 5
      run_frame("timeout",  64'h02A6_1234_5678_0005, 8'hC1, 0, 5, -1, 1'b0, 32, 0);
      // restart and input change mid-frame: still the start-time snapshot, one frame
      run_frame("disturb",  64'h02A6_1234_5678_0005, 8'hC1, 0, -1, -1, 1'b1, 32, 330);
      // reset during SHHI of bit 10, then a clean frame
      run_frame("rst_mid",  64'h0000_0000_0019_0000, 8'h08, 0, -1, 10, 1'b0, 16, 0);
      run_frame("after_rst", 64'h0000_0000_0019_0000, 8'h08, 0, -1, -1, 1'b0, 16, 170);
      // every channel empty: 1+4+0+4+1 = 10
      run_frame("all_empty", 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, -1, -1, 1'b0, 0, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
